// File: rtl/tone_pkg.sv
// tone_pkg: shared definitions for the tone oscillator slice.
//   PERIOD_W_DEF : default width of the period input and the phase counter
//   REST_MAX     : largest period value that means "rest" (silence)
//   tone_state_t : oscillator state (IDLE, HIGH, LOW)
//   half()       : length of the LOW phase for a given period (P >> 1)
package tone_pkg;

  localparam int PERIOD_W_DEF = 19;
  localparam int REST_MAX     = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } tone_state_t;

  function automatic logic [PERIOD_W_DEF-1:0] half(input logic [PERIOD_W_DEF-1:0] p);
    return p >> 1;
  endfunction

endpackage

// File: rtl/tone_env.sv
// tone_env: decaying amplitude envelope with PWM gating for tone_osc.
// Only instantiated when TONE_OSC_ENV_EN is defined.
// Ports:
//   clk48m   in   system clock, 48 MHz
//   rst_n    in   asynchronous active-low reset
//   restart  in   new note adopted: amplitude jumps to full scale
//   clr      in   oscillator disabled: amplitude and prescaler cleared
//   gate     out  1 while the free-running PWM counter is below the amplitude
module tone_env #(
  parameter int ENV_STEP = 48000,
  parameter int PWM_W    = 8
) (
  input  logic clk48m,
  input  logic rst_n,
  input  logic restart,
  input  logic clr,
  output logic gate
);

  localparam int PRE_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] amp;
  logic [PWM_W-1:0] pwm_cnt;

  // The prescaler restarts with each note so the first decrement comes a
  // full ENV_STEP after the note begins.
  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      amp     <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
      amp     <= '0;
    end else if (restart) begin
      pre_cnt <= '0;
      amp     <= '1;
    end else if (pre_cnt == PRE_W'(ENV_STEP - 1)) begin
      pre_cnt <= '0;
      if (amp != '0) begin
        amp <= amp - 1'b1;
      end
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign gate = (pwm_cnt < amp);

endmodule

// File: rtl/tone_osc.sv
// tone_osc: renders a note period (in clk48m cycles) as a square-wave audio
// bitstream. Period changes are taken only at the end of the LOW phase so
// tones switch without glitches; periods 0 and 1 are rests.
// Optional feature: define TONE_OSC_ENV_EN to add a decaying PWM envelope
// (tone_env) that gates the square wave.
// Ports:
//   clk48m      in   system clock, 48 MHz
//   rst_n       in   asynchronous active-low reset
//   period      in   requested tone period in clocks (level, may change any cycle)
//   enable      in   0 = mute and hold idle
//   audio_out   out  audio bitstream
//   note_start  out  1-cycle pulse when a new non-rest period is adopted
//   active      out  1 while a tone is running (HIGH or LOW)
module tone_osc
  import tone_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF
`ifdef TONE_OSC_ENV_EN
  ,
  parameter int ENV_STEP = 48000,
  parameter int PWM_W    = 8
`endif
) (
  input  logic                clk48m,
  input  logic                rst_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                enable,
  output logic                audio_out,
  output logic                note_start,
  output logic                active
);

  tone_state_t         state, state_nxt;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_act, act_nxt;
  logic [PERIOD_W-1:0] phase_cnt, cnt_nxt;
  logic                start_nxt;
  logic                rest_q;
  logic                square;

  // Input register: every decision looks at period_q, never the raw input.
  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
    end else begin
      period_q <= period;
    end
  end

  assign rest_q = (period_q <= PERIOD_W'(REST_MAX));

  // State register
  always_ff @(posedge clk48m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_act <= '0;
      phase_cnt  <= '0;
      note_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      period_act <= act_nxt;
      phase_cnt  <= cnt_nxt;
      note_start <= start_nxt;
    end
  end

  // Next-state logic. phase_cnt counts down and a phase ends when it reads 1.
  // A new period is adopted only from IDLE or at the end of LOW; adopting
  // preloads the HIGH length P - (P >> 1) so odd periods favour HIGH.
  always_comb begin
    state_nxt = state;
    act_nxt   = period_act;
    cnt_nxt   = phase_cnt;
    start_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      act_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rest_q) begin
            state_nxt = HIGH;
            act_nxt   = period_q;
            cnt_nxt   = period_q - half(period_q);
            start_nxt = 1'b1;
          end
        end
        HIGH: begin
          if (phase_cnt == PERIOD_W'(1)) begin
            state_nxt = LOW;
            cnt_nxt   = half(period_act);
          end else begin
            cnt_nxt = phase_cnt - 1'b1;
          end
        end
        LOW: begin
          if (phase_cnt == PERIOD_W'(1)) begin
            if (period_q == period_act) begin
              state_nxt = HIGH;
              cnt_nxt   = period_act - half(period_act);
            end else if (!rest_q) begin
              state_nxt = HIGH;
              act_nxt   = period_q;
              cnt_nxt   = period_q - half(period_q);
              start_nxt = 1'b1;
            end else begin
              state_nxt = IDLE;
              act_nxt   = '0;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = phase_cnt - 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          act_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode straight from the state register, so an asynchronous
  // reset silences the pin immediately.
  always_comb begin
    square = (state == HIGH);
    active = (state != IDLE);
  end

`ifdef TONE_OSC_ENV_EN
  logic env_gate;

  // restart uses the adoption decision itself so full amplitude coincides
  // with the first HIGH cycle of the note.
  tone_env #(
    .ENV_STEP(ENV_STEP),
    .PWM_W   (PWM_W)
  ) u_env (
    .clk48m (clk48m),
    .rst_n  (rst_n),
    .restart(start_nxt),
    .clr    (!enable),
    .gate   (env_gate)
  );

  assign audio_out = square & env_gate;
`else
  assign audio_out = square;
`endif

endmodule

// File: tb/tb_tone_osc.sv
// tb_tone_osc: directed testbench for tone_osc (default build, envelope off).
// Drives note periods, rests, enable drops and a mid-tone reset, and checks
// phase lengths, note_start pulses and the active flag against hand-computed
// values.
module tb_tone_osc;

  logic        clk48m;
  logic        rst_n;
  logic [18:0] period;
  logic        enable;
  logic        audio_out;
  logic        note_start;
  logic        active;

  int checks = 0;
  int errors = 0;

  tone_osc dut (
    .clk48m    (clk48m),
    .rst_n     (rst_n),
    .period    (period),
    .enable    (enable),
    .audio_out (audio_out),
    .note_start(note_start),
    .active    (active)
  );

  initial clk48m = 1'b0;
  always #5 clk48m = ~clk48m;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [18:0] p, input logic en);
    period = p;
    enable = en;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk48m);
  endtask

  // Counts consecutive samples with audio_out == lvl starting at the current
  // sample; optionally changes period after change_at samples. Bounded.
  task automatic measurePhase(input string tag, input logic lvl, input int expected,
                              input int change_at, input logic [18:0] new_period);
    int n = 0;
    while (audio_out === lvl && n < expected + 10) begin
      if (n == change_at) period = new_period;
      n++;
      @(negedge clk48m);
    end
    checkOutput(tag, n, expected);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(19'd0, 1'b0);
    waitCycles(1);
    checkOutput("reset_audio", audio_out, 0);
    checkOutput("reset_note_start", note_start, 0);
    checkOutput("reset_active", active, 0);
    rst_n = 1'b1;
    waitCycles(2);

    // Period 100 from IDLE: note_start on the second edge, then 50/50.
    applyStimulus(19'd100, 1'b1);
    waitCycles(1);
    checkOutput("p100_edge1_audio", audio_out, 0);
    checkOutput("p100_edge1_start", note_start, 0);
    waitCycles(1);
    checkOutput("p100_edge2_audio", audio_out, 1);
    checkOutput("p100_edge2_start", note_start, 1);
    checkOutput("p100_edge2_active", active, 1);
    measurePhase("p100_high1", 1'b1, 50, -1, 19'd0);
    measurePhase("p100_low1", 1'b0, 50, -1, 19'd0);
    checkOutput("p100_repeat_no_start", note_start, 0);
    measurePhase("p100_high2", 1'b1, 50, 0, 19'd101);
    measurePhase("p100_low2", 1'b0, 50, -1, 19'd0);

    // Odd period 101: extra cycle lands in HIGH.
    checkOutput("p101_start", note_start, 1);
    period = 19'd2;
    measurePhase("p101_high", 1'b1, 51, -1, 19'd0);
    measurePhase("p101_low", 1'b0, 50, -1, 19'd0);

    // Minimum period 2: one cycle each.
    checkOutput("p2_start", note_start, 1);
    measurePhase("p2_high1", 1'b1, 1, -1, 19'd0);
    measurePhase("p2_low1", 1'b0, 1, -1, 19'd0);
    checkOutput("p2_repeat_no_start", note_start, 0);
    period = 19'd100;
    measurePhase("p2_high2", 1'b1, 1, -1, 19'd0);
    measurePhase("p2_low2", 1'b0, 1, -1, 19'd0);

    // Change 100 -> 60 mid-HIGH: current cycle completes, then 30/30.
    checkOutput("p100b_start", note_start, 1);
    measurePhase("p100b_high", 1'b1, 50, 20, 19'd60);
    checkOutput("p100b_no_start_midcycle", note_start, 0);
    measurePhase("p100b_low", 1'b0, 50, -1, 19'd0);
    checkOutput("p60_start", note_start, 1);
    measurePhase("p60_high1", 1'b1, 30, -1, 19'd0);
    measurePhase("p60_low1", 1'b0, 30, -1, 19'd0);
    checkOutput("p60_repeat_no_start", note_start, 0);
    measurePhase("p60_high2", 1'b1, 30, -1, 19'd0);

    // Rest requested mid-LOW: LOW finishes, then IDLE.
    waitCycles(10);
    period = 19'd0;
    waitCycles(19);
    checkOutput("rest_last_low_active", active, 1);
    checkOutput("rest_last_low_audio", audio_out, 0);
    waitCycles(1);
    checkOutput("rest_idle_active", active, 0);
    checkOutput("rest_idle_audio", audio_out, 0);
    checkOutput("rest_idle_start", note_start, 0);
    waitCycles(5);
    checkOutput("rest_hold_audio", audio_out, 0);
    checkOutput("rest_hold_active", active, 0);
    period = 19'd100;
    waitCycles(1);
    checkOutput("after_rest_edge1_start", note_start, 0);
    waitCycles(1);
    checkOutput("after_rest_edge2_start", note_start, 1);
    measurePhase("after_rest_high", 1'b1, 50, -1, 19'd0);
    measurePhase("after_rest_low", 1'b0, 50, -1, 19'd0);

    // enable drop mid-HIGH, then a fresh start.
    waitCycles(10);
    applyStimulus(19'd0, 1'b0);
    waitCycles(1);
    checkOutput("disable_audio", audio_out, 0);
    checkOutput("disable_active", active, 0);
    checkOutput("disable_start", note_start, 0);
    waitCycles(3);
    applyStimulus(19'd100, 1'b1);
    waitCycles(1);
    checkOutput("reenable_edge1_start", note_start, 0);
    waitCycles(1);
    checkOutput("reenable_edge2_start", note_start, 1);
    measurePhase("reenable_high", 1'b1, 50, -1, 19'd0);
    measurePhase("reenable_low", 1'b0, 50, -1, 19'd0);

    // Asynchronous reset mid-HIGH silences output before the next edge.
    waitCycles(5);
    checkOutput("pre_reset_audio", audio_out, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_audio", audio_out, 0);
    checkOutput("async_reset_active", active, 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("post_reset_edge1_start", note_start, 0);
    waitCycles(1);
    checkOutput("post_reset_edge2_start", note_start, 1);
    measurePhase("post_reset_high", 1'b1, 50, -1, 19'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
